multi_servo_controller: RTL and testbench
=========================================

MULTI_SERVO_CONTROLLER -- requirements
Module: multi_servo_controller

Interface
REQ-001 The parameter NUM_SERVOS SHALL default to 4 and set the servo channel count (legal range 1..8).
REQ-002 The parameter CLK_HZ SHALL default to 25_000_000 and set the input clock frequency in Hz.
REQ-003 The parameter SLEW_US SHALL default to 10 and set the maximum command change in us per 1 ms update tick.
REQ-004 The parameter DEBOUNCE_MS SHALL default to 10 and set the button stable time in ms.
REQ-005 The parameter STALE_MS SHALL default to 100 and set the joystick-sample timeout in ms.
REQ-006 Port CLK SHALL be an input, 1 bit: the single system clock.
REQ-007 Port RST_N SHALL be an input, 1 bit: the reset, asynchronous and active-low.
REQ-008 Port x_pos SHALL be an input, 10 bits: the joystick X ADC sample.
REQ-009 Port pos_valid SHALL be an input, 1 bit: a one-cycle strobe marking a new x_pos.
REQ-010 Port sel_btn SHALL be an input, NUM_SERVOS bits: raw, asynchronous, active-high select buttons.
REQ-011 Port sel_led SHALL be an output, NUM_SERVOS bits: one-hot indication of the selected channel.
REQ-012 Port pwm SHALL be an output, NUM_SERVOS bits: one servo pulse signal per channel.
REQ-013 Port stale SHALL be an output, 1 bit: high while the joystick input is timed out.

Function
REQ-014 Each sel_btn bit SHALL pass through a 2-flop synchronizer, then a debouncer that accepts a new level only after it is stable for DEBOUNCE_MS.
REQ-015 A debounced rising edge on bit i SHALL select channel i on the next cycle; on simultaneous edges the lowest index SHALL win.
REQ-016 The selected-channel index SHALL hold until another edge occurs; sel_led SHALL equal the one-hot form of that index.
REQ-017 On each pos_valid, the block SHALL clamp x_pos to 228..830 and register target_us = 650 + floor((x_clamped-228)*1950/602), computed in at least 22-bit unsigned arithmetic.
REQ-018 target_us SHALL apply only to the selected channel; non-selected channels SHALL retain their commands.
REQ-019 A free-running 1 ms tick, derived from CLK_HZ, SHALL advance the slew limiter.
REQ-020 On each tick, the selected channel's cmd_us SHALL move toward target_us by min(|target-cmd|, SLEW_US) and SHALL never overshoot.
REQ-021 On a selection change, the new channel's target_us SHALL be loaded with its current cmd_us, so the new channel does not jump.
REQ-022 The stale output SHALL assert when STALE_MS ticks elapse with no pos_valid; while stale is high, targets SHALL freeze and slewing SHALL stop; the next pos_valid SHALL clear stale in the same cycle that it loads the target.
REQ-023 Each pwm channel SHALL use a 20 ms frame built from a 1 us prescaled tick; the output SHALL be high for cmd_us us from frame start and low for the rest of the frame.
REQ-024 cmd_us SHALL be sampled into the PWM compare register only at frame start, so no glitched or truncated pulses occur.
REQ-025 All channels SHALL share one frame counter and SHALL be phase-aligned.

Reset
REQ-026 While RST_N is low: every cmd_us and target_us = 1500; selected index = 0; sel_led = 1 (one-hot bit 0); pwm = 0; stale = 1; all counters and debouncers cleared.
REQ-027 On RST_N release, the first PWM frame SHALL start within 2 cycles; a reset asserted mid-pulse SHALL drive pwm low immediately.

Structure
REQ-028 A shared package servo_pkg SHALL hold SERVO_MIN_US=650, SERVO_MAX_US=2600, SERVO_CENTER_US=1500, JOY_MIN=228, JOY_MAX=830, FRAME_US=20000.
REQ-029 One sub-module, servo_pwm, SHALL be instantiated NUM_SERVOS times and take the shared frame count plus its own cmd_us; the debouncer SHALL be inline.

Verification
REQ-030 Reset, then observe with no input -> all pwm pulses 1500 us every 20 ms, sel_led=0001, stale=1.
REQ-031 x_pos=830 strobe, channel 0 selected -> cmd rises by 10 us/ms and reaches 2600 after 110 ticks; channels 1..3 stay at 1500.
REQ-032 x_pos=100 and x_pos=1000 -> targets clamp to 650 and 2600; x_pos=529 -> target 1625.
REQ-033 4 ms bounce on sel_btn[2], then stable high -> exactly one selection change, to channel 2; buttons 1 and 3 pressed in the same cycle -> channel 1 selected.
REQ-034 Stop pos_valid for 100 ms mid-slew -> stale=1, cmd frozen; one strobe -> stale=0 and slewing resumes.
REQ-035 Change cmd mid-frame -> the current pulse width is unchanged, and the new width appears in the next frame.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants, types and arithmetic helpers for the multi-channel servo controller.
package servo_pkg;
  localparam int SERVO_MIN_US    = 650;
  localparam int SERVO_MAX_US    = 2600;
  localparam int SERVO_CENTER_US = 1500;
  localparam int JOY_MIN         = 228;
  localparam int JOY_MAX         = 830;
  localparam int FRAME_US        = 20000;
  localparam int US_W            = 12;
  localparam int FRAME_W         = 15;

  typedef logic [US_W-1:0]    us_t;
  typedef logic [FRAME_W-1:0] frame_t;

  // Clamp the joystick sample and map it linearly onto the servo pulse range.
  function automatic us_t joy_to_us(input logic [9:0] x);
    logic [9:0]  x_c;
    logic [21:0] prod;
    logic [21:0] quot;
    if (x < 10'(JOY_MIN))
      x_c = 10'(JOY_MIN);
    else if (x > 10'(JOY_MAX))
      x_c = 10'(JOY_MAX);
    else
      x_c = x;
    prod = 22'(x_c - 10'(JOY_MIN)) * 22'd1950;
    quot = prod / 22'd602;
    return us_t'(quot) + us_t'(SERVO_MIN_US);
  endfunction

  function automatic us_t slew_step(input us_t cmd, input us_t target, input us_t step);
    if (target > cmd)
      return ((target - cmd) > step) ? cmd + step : target;
    else if (cmd > target)
      return ((cmd - target) > step) ? cmd - step : target;
    else
      return cmd;
  endfunction
endpackage

// File: rtl/servo_pwm.sv
// One servo pulse generator; the width is latched at frame start so a pulse is never cut short.
module servo_pwm
  import servo_pkg::*;
(
  input  logic   CLK,
  input  logic   RST_N,
  input  logic   us_tick,
  input  frame_t frame_cnt,
  input  us_t    cmd_us,
  output logic   pwm
);
  us_t  compare_reg;
  logic pwm_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      compare_reg <= us_t'(SERVO_CENTER_US);
      pwm_reg     <= 1'b0;
    end else if (us_tick) begin
      if (frame_cnt == '0) begin
        compare_reg <= cmd_us;
        pwm_reg     <= (cmd_us != '0);
      end else begin
        pwm_reg <= (frame_cnt < frame_t'(compare_reg));
      end
    end
  end

  assign pwm = pwm_reg;
endmodule

// File: rtl/multi_servo_controller.sv
// Joystick-driven servo controller: button channel select, slew-limited commands,
// stale-input freeze and phase-aligned PWM outputs.
module multi_servo_controller
  import servo_pkg::*;
#(
  parameter int NUM_SERVOS  = 4,
  parameter int CLK_HZ      = 25_000_000,
  parameter int SLEW_US     = 10,
  parameter int DEBOUNCE_MS = 10,
  parameter int STALE_MS    = 100
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [9:0]            x_pos,
  input  logic                  pos_valid,
  input  logic [NUM_SERVOS-1:0] sel_btn,
  output logic [NUM_SERVOS-1:0] sel_led,
  output logic [NUM_SERVOS-1:0] pwm,
  output logic                  stale
);
  // Divisors floor at 1 so very slow clocks still produce one tick per cycle.
  localparam int US_DIV    = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
  localparam int MS_DIV    = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int DB_CYCLES = (DEBOUNCE_MS * MS_DIV > 0) ? DEBOUNCE_MS * MS_DIV : 1;
  localparam int US_DIV_W  = $clog2(US_DIV + 1);
  localparam int MS_DIV_W  = $clog2(MS_DIV + 1);
  localparam int DB_W      = $clog2(DB_CYCLES + 1);
  localparam int STALE_W   = $clog2(STALE_MS + 1);
  localparam int IDX_W     = (NUM_SERVOS > 1) ? $clog2(NUM_SERVOS) : 1;

  logic [US_DIV_W-1:0]   us_div_reg;
  logic [MS_DIV_W-1:0]   ms_div_reg;
  frame_t                frame_cnt_reg;
  logic                  us_tick;
  logic                  ms_tick;
  logic [STALE_W-1:0]    stale_cnt_reg;
  logic                  stale_reg;
  logic [IDX_W-1:0]      sel_idx_reg;
  logic [IDX_W-1:0]      sel_idx_next;
  logic [IDX_W-1:0]      new_idx;
  logic [NUM_SERVOS-1:0] rise;
  us_t                   cmd_reg     [NUM_SERVOS];
  us_t                   cmd_next    [NUM_SERVOS];
  us_t                   target_reg  [NUM_SERVOS];
  us_t                   target_next [NUM_SERVOS];

  assign us_tick = (us_div_reg == '0);
  assign ms_tick = (ms_div_reg == MS_DIV_W'(MS_DIV - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      us_div_reg    <= '0;
      ms_div_reg    <= '0;
      frame_cnt_reg <= '0;
    end else begin
      us_div_reg <= (us_div_reg == US_DIV_W'(US_DIV - 1)) ? '0 : us_div_reg + 1'b1;
      ms_div_reg <= ms_tick ? '0 : ms_div_reg + 1'b1;
      if (us_tick)
        frame_cnt_reg <= (frame_cnt_reg == frame_t'(FRAME_US - 1)) ? '0 : frame_cnt_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SERVOS; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            db_reg;
      logic [DB_W-1:0] db_cnt_reg;
      logic            db_done;

      assign db_done = (db_cnt_reg == DB_W'(DB_CYCLES - 1));

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          db_reg     <= 1'b0;
          db_cnt_reg <= '0;
        end else begin
          sync1_reg <= sel_btn[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == db_reg) begin
            db_cnt_reg <= '0;
          end else if (db_done) begin
            db_reg     <= sync2_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
      end

      assign rise[gi] = sync2_reg & ~db_reg & db_done;
    end

    for (gi = 0; gi < NUM_SERVOS; gi++) begin : g_pwm
      servo_pwm u_pwm (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .us_tick   (us_tick),
        .frame_cnt (frame_cnt_reg),
        .cmd_us    (cmd_reg[gi]),
        .pwm       (pwm[gi])
      );
    end
  endgenerate

  always_comb begin
    new_idx = '0;
    for (int i = NUM_SERVOS - 1; i >= 0; i--)
      if (rise[i]) new_idx = IDX_W'(i);
  end

  // A newly selected channel adopts its present command as target so it holds still.
  always_comb begin
    cmd_next     = cmd_reg;
    target_next  = target_reg;
    sel_idx_next = sel_idx_reg;
    if (pos_valid)
      target_next[sel_idx_reg] = joy_to_us(x_pos);
    if (ms_tick && !stale_reg)
      cmd_next[sel_idx_reg] = slew_step(cmd_reg[sel_idx_reg], target_reg[sel_idx_reg],
                                        us_t'(SLEW_US));
    if (|rise) begin
      sel_idx_next         = new_idx;
      target_next[new_idx] = cmd_next[new_idx];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_SERVOS; i++) begin
        cmd_reg[i]    <= us_t'(SERVO_CENTER_US);
        target_reg[i] <= us_t'(SERVO_CENTER_US);
      end
      sel_idx_reg <= '0;
    end else begin
      cmd_reg     <= cmd_next;
      target_reg  <= target_next;
      sel_idx_reg <= sel_idx_next;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stale_reg     <= 1'b1;
      stale_cnt_reg <= '0;
    end else if (pos_valid) begin
      stale_reg     <= 1'b0;
      stale_cnt_reg <= '0;
    end else if (ms_tick && !stale_reg) begin
      if (stale_cnt_reg == STALE_W'(STALE_MS - 1)) begin
        stale_reg     <= 1'b1;
        stale_cnt_reg <= '0;
      end else begin
        stale_cnt_reg <= stale_cnt_reg + 1'b1;
      end
    end
  end

  assign stale   = stale_reg;
  assign sel_led = NUM_SERVOS'(1) << sel_idx_reg;
endmodule

// File: tb/tb_multi_servo_controller.sv
// Directed bench: a 100 kHz clock makes 1 us = 1 cycle and 1 ms = 100 cycles.
`timescale 1ns/1ps
module tb_multi_servo_controller;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [9:0] x_pos = '0;
  logic       pos_valid = 1'b0;
  logic [3:0] sel_btn = '0;
  logic [3:0] sel_led;
  logic [3:0] pwm;
  logic       stale;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int rise_cyc [4] = '{0, 0, 0, 0};
  int width_c  [4] = '{0, 0, 0, 0};
  int period_c [4] = '{0, 0, 0, 0};
  int n_rise   [4] = '{0, 0, 0, 0};
  int n_fall   [4] = '{0, 0, 0, 0};
  int sel_changes = 0;
  logic [3:0] pwm_prev = '0;
  logic [3:0] led_prev = 4'b0001;

  multi_servo_controller #(
    .NUM_SERVOS  (4),
    .CLK_HZ      (100_000),
    .SLEW_US     (10),
    .DEBOUNCE_MS (10),
    .STALE_MS    (100)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .x_pos     (x_pos),
    .pos_valid (pos_valid),
    .sel_btn   (sel_btn),
    .sel_led   (sel_led),
    .pwm       (pwm),
    .stale     (stale)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor: widths and periods measured in clock cycles (= us here).
  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (pwm[i] && !pwm_prev[i]) begin
        period_c[i] = cyc - rise_cyc[i];
        rise_cyc[i] = cyc;
        n_rise[i]++;
      end
      if (!pwm[i] && pwm_prev[i]) begin
        width_c[i] = cyc - rise_cyc[i];
        n_fall[i]++;
      end
    end
    pwm_prev = pwm;
    if (sel_led !== led_prev) sel_changes++;
    led_prev = sel_led;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [9:0] x);
    x_pos     = x;
    pos_valid = 1'b1;
    @(negedge CLK);
    pos_valid = 1'b0;
  endtask

  task automatic strobe_check(input logic [9:0] x, input int exp_target);
    strobe(x);
    check($sformatf("target_x%0d", x), 32'(dut.target_reg[0]), 32'(exp_target));
    $display("[TB] strobe x_pos=%0d target=%0d", x, dut.target_reg[0]);
  endtask

  initial begin
    int old;
    int k;
    int rc;
    int base_changes;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_pwm", 32'(pwm), 32'h0);
    check("rst_led", 32'(sel_led), 32'h1);
    check("rst_stale", 32'(stale), 32'h1);
    check("rst_cmd0", 32'(dut.cmd_reg[0]), 32'd1500);
    check("rst_target3", 32'(dut.target_reg[3]), 32'd1500);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    check("frame_start_after_rst", 32'(pwm), 32'hF);

    // Reset asserted mid-pulse must drop pwm at once
    repeat (100) @(negedge CLK);
    check("pwm_high_mid_pulse", 32'(pwm), 32'hF);
    #2 RST_N = 1'b0;
    #1 check("pwm_async_rst", 32'(pwm), 32'h0);
    check("async_rst_stale", 32'(stale), 32'h1);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    check("frame_start_after_rst2", 32'(pwm), 32'hF);
    $display("[TB] reset sequence done pwm=%b led=%b stale=%0d", pwm, sel_led, stale);

    // Slew channel 0 toward 2600 at 10 us/ms
    strobe(10'd830);
    check("stale_clear", 32'(stale), 32'h0);
    check("target_830", 32'(dut.target_reg[0]), 32'd2600);
    for (k = 0; k < 300 && dut.cmd_reg[0] == 12'd1500; k++) @(negedge CLK);
    check("slew_tick1", 32'(dut.cmd_reg[0]), 32'd1510);
    repeat (100) @(negedge CLK);
    check("slew_tick2", 32'(dut.cmd_reg[0]), 32'd1520);
    strobe(10'd830);
    repeat (4999) @(negedge CLK);
    check("slew_tick52", 32'(dut.cmd_reg[0]), 32'd2020);
    strobe(10'd830);
    repeat (5799) @(negedge CLK);
    check("slew_tick110", 32'(dut.cmd_reg[0]), 32'd2600);
    repeat (1000) @(negedge CLK);
    check("slew_no_overshoot", 32'(dut.cmd_reg[0]), 32'd2600);
    for (int i = 1; i < 4; i++)
      check($sformatf("cmd_hold_ch%0d", i), 32'(dut.cmd_reg[i]), 32'd1500);
    $display("[TB] slew ch0 reached cmd=%0d", dut.cmd_reg[0]);

    // First frame after reset: every channel 1500 us
    for (int i = 0; i < 4; i++)
      check($sformatf("frame0_width_ch%0d", i), 32'(width_c[i]), 32'd1500);
    $display("[TB] frame0 widths %0d %0d %0d %0d", width_c[0], width_c[1], width_c[2], width_c[3]);

    // Clamping and scaling
    strobe_check(10'd100, 650);
    strobe_check(10'd529, 1625);
    strobe_check(10'd300, 883);
    strobe_check(10'd228, 650);
    strobe_check(10'd1000, 2600);

    // Command change mid-frame: current pulse keeps its width
    old = n_rise[0];
    for (k = 0; k < 25000 && n_rise[0] == old; k++) @(negedge CLK);
    check("frame1_rise_seen", 32'(n_rise[0] != old), 32'h1);
    rc = rise_cyc[0];
    strobe(10'd100);
    old = n_fall[0];
    for (k = 0; k < 3000 && n_fall[0] == old; k++) @(negedge CLK);
    check("frame1_width_ch0", 32'(width_c[0]), 32'd2600);
    check("frame1_width_ch1", 32'(width_c[1]), 32'd1500);
    $display("[TB] frame1 width ch0=%0d ch1=%0d", width_c[0], width_c[1]);
    while (cyc - rc < 7000) @(negedge CLK);
    strobe(10'd100);
    while (cyc - rc < 14000) @(negedge CLK);
    strobe(10'd100);
    old = n_rise[0];
    for (k = 0; k < 25000 && n_rise[0] == old; k++) @(negedge CLK);
    check("frame_period", 32'(period_c[0]), 32'd20000);
    old = n_fall[0];
    for (k = 0; k < 3000 && n_fall[0] == old; k++) @(negedge CLK);
    check("frame2_width_ch0", 32'(width_c[0]), 32'd650);
    $display("[TB] frame2 period=%0d width ch0=%0d", period_c[0], width_c[0]);

    // Stale timeout mid-slew freezes the command
    strobe(10'd1000);
    repeat (9850) @(negedge CLK);
    check("stale_before_timeout", 32'(stale), 32'h0);
    repeat (200) @(negedge CLK);
    check("stale_after_timeout", 32'(stale), 32'h1);
    check("stale_cmd", 32'(dut.cmd_reg[0]), 32'd1650);
    repeat (500) @(negedge CLK);
    check("stale_cmd_frozen", 32'(dut.cmd_reg[0]), 32'd1650);
    strobe(10'd1000);
    check("stale_cleared", 32'(stale), 32'h0);
    repeat (100) @(negedge CLK);
    check("slew_resumed", 32'(dut.cmd_reg[0]), 32'd1660);
    $display("[TB] stale test cmd=%0d stale=%0d", dut.cmd_reg[0], stale);

    // Bouncing button 2, then stable high
    base_changes = sel_changes;
    for (int b = 0; b < 8; b++) begin
      sel_btn[2] = ~sel_btn[2];
      repeat (50) @(negedge CLK);
    end
    sel_btn[2] = 1'b1;
    check("bounce_no_select", 32'(sel_led), 32'h1);
    repeat (1200) @(negedge CLK);
    check("select_ch2", 32'(sel_led), 32'h4);
    check("one_change", 32'(sel_changes - base_changes), 32'd1);
    check("ch2_target_adopts_cmd", 32'(dut.target_reg[2]), 32'd1500);
    strobe(10'd529);
    check("ch2_target_529", 32'(dut.target_reg[2]), 32'd1625);
    check("ch0_target_kept", 32'(dut.target_reg[0]), 32'd2600);
    $display("[TB] button2 sel_led=%b changes=%0d", sel_led, sel_changes - base_changes);

    // Release, then buttons 1 and 3 together: lowest index wins
    sel_btn = 4'b0000;
    repeat (1200) @(negedge CLK);
    check("release_keeps_sel", 32'(sel_led), 32'h4);
    sel_btn = 4'b1010;
    repeat (1200) @(negedge CLK);
    check("select_ch1_priority", 32'(sel_led), 32'h2);
    check("two_changes", 32'(sel_changes - base_changes), 32'd2);
    check("ch1_target_adopts_cmd", 32'(dut.target_reg[1]), 32'd1500);
    $display("[TB] buttons 1+3 sel_led=%b", sel_led);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
